// File: rtl/scan_decoder.sv
// One-hot decoder with direct select and auto-scan modes; registered outputs, 1-cycle latency.
// Scan holds each index for div+1 cycles and pulses wrap when the index rolls over to 0.
module scan_decoder #(
   parameter int SEL_W   = 3,
   parameter int DIV_W   = 16,
   parameter int ACT_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [DIV_W-1:0]        div,
   output logic [(2**SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int OUT_N = 2**SEL_W;
   localparam logic [OUT_N-1:0] OFF_VAL = (ACT_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  presc;

   // Polarity is folded in here so the out register already holds the pin value.
   function automatic logic [OUT_N-1:0] drive(input logic [SEL_W-1:0] s);
      logic [OUT_N-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return (ACT_LOW != 0) ? ~v : v;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= OFF;
         idx   <= '0;
         presc <= '0;
         wrap  <= 1'b0;
         out   <= OFF_VAL;
      end else if (!en) begin
         state <= OFF;
         out   <= OFF_VAL;
         wrap  <= 1'b0;
      end else if (!mode) begin
         state <= DIRECT;
         idx   <= sel;
         out   <= drive(sel);
         presc <= '0;
         wrap  <= 1'b0;
      end else if (state != SCAN) begin
         state <= SCAN;
         idx   <= sel;
         out   <= drive(sel);
         presc <= '0;
         wrap  <= 1'b0;
      end else if (presc >= div) begin
         // >= rather than == so a div lowered mid-dwell ticks at once instead of overrunning.
         presc <= '0;
         idx   <= idx + 1'b1;
         out   <= drive(idx + 1'b1);
         wrap  <= (idx == LAST_IDX);
      end else begin
         presc <= presc + 1'b1;
         wrap  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: an active-high and an ACT_LOW copy share stimulus.
module tb_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        mode;
   logic [2:0]  sel;
   logic [15:0] div;
   logic [7:0]  out;
   logic [2:0]  idx;
   logic        wrap;
   logic [7:0]  out_l;
   logic [2:0]  idx_l;
   logic        wrap_l;

   int n_cmp = 0;
   int n_bad = 0;

   scan_decoder #(.SEL_W(3), .DIV_W(16), .ACT_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .div(div),
      .out(out), .idx(idx), .wrap(wrap)
   );

   scan_decoder #(.SEL_W(3), .DIV_W(16), .ACT_LOW(1)) dut_l (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .div(div),
      .out(out_l), .idx(idx_l), .wrap(wrap_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd5; div = 16'd0;
      step();
      step();
      n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL rst_out got %h want 00", out); end
      n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL rst_idx got %0d want 0", idx); end
      n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL rst_wrap got %b want 0", wrap); end
      n_cmp++; if (out_l !== 8'hFF) begin n_bad++; $display("FAIL rst_out_l got %h want ff", out_l); end
      rst_n = 1'b1; en = 1'b0;
      step();
      n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL off_out got %h want 00", out); end
      n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL off_idx got %0d want 0", idx); end
   endtask

   task automatic test_direct();
      logic [3:0] v;
      logic [7:0] exp;
      mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
         v   = 4'(i);
         en  = v[3];
         sel = v[2:0];
         step();
         exp = v[3] ? (8'd1 << v[2:0]) : 8'h00;
         n_cmp++; if (out !== exp) begin n_bad++; $display("FAIL dir_out v=%0d got %h want %h", i, out, exp); end
         n_cmp++; if (out_l !== ~exp) begin n_bad++; $display("FAIL dir_out_l v=%0d got %h want %h", i, out_l, ~exp); end
         n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL dir_wrap v=%0d got %b want 0", i, wrap); end
         if (v[3]) begin
            n_cmp++; if (idx !== v[2:0]) begin n_bad++; $display("FAIL dir_idx v=%0d got %0d want %0d", i, idx, v[2:0]); end
         end
      end
   endtask

   task automatic test_scan_dwell();
      logic [2:0] exp_idx [15] = '{3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7,
                                   3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
      logic exp_wrap;
      en = 1'b0;
      step();
      en = 1'b1; mode = 1'b1; sel = 3'd5; div = 16'd2;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i == 2) sel = 3'd2;
         exp_wrap = (i == 9);
         n_cmp++; if (idx !== exp_idx[i]) begin n_bad++; $display("FAIL dwell_idx c=%0d got %0d want %0d", i, idx, exp_idx[i]); end
         n_cmp++; if (out !== (8'd1 << exp_idx[i])) begin n_bad++; $display("FAIL dwell_out c=%0d got %h want %h", i, out, 8'd1 << exp_idx[i]); end
         n_cmp++; if (wrap !== exp_wrap) begin n_bad++; $display("FAIL dwell_wrap c=%0d got %b want %b", i, wrap, exp_wrap); end
      end
   endtask

   task automatic test_fast_scan();
      logic [2:0] e;
      en = 1'b0;
      step();
      en = 1'b1; mode = 1'b1; sel = 3'd0; div = 16'd0;
      step();
      n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL fast_entry_idx got %0d want 0", idx); end
      n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL fast_entry_wrap got %b want 0", wrap); end
      for (int i = 1; i < 18; i++) begin
         step();
         e = 3'(i % 8);
         n_cmp++; if (idx !== e) begin n_bad++; $display("FAIL fast_idx c=%0d got %0d want %0d", i, idx, e); end
         n_cmp++; if (wrap !== (e == 3'd0)) begin n_bad++; $display("FAIL fast_wrap c=%0d got %b want %b", i, wrap, e == 3'd0); end
         n_cmp++; if (out !== (8'd1 << e)) begin n_bad++; $display("FAIL fast_out c=%0d got %h want %h", i, out, 8'd1 << e); end
      end
   endtask

   task automatic test_div_shrink();
      en = 1'b0;
      step();
      en = 1'b1; mode = 1'b1; sel = 3'd3; div = 16'd100;
      step();
      for (int i = 0; i < 50; i++) step();
      n_cmp++; if (idx !== 3'd3) begin n_bad++; $display("FAIL shrink_hold got %0d want 3", idx); end
      div = 16'd10;
      step();
      n_cmp++; if (idx !== 3'd4) begin n_bad++; $display("FAIL shrink_tick got %0d want 4", idx); end
      for (int i = 0; i < 10; i++) begin
         step();
         n_cmp++; if (idx !== 3'd4) begin n_bad++; $display("FAIL shrink_dwell c=%0d got %0d want 4", i, idx); end
      end
      step();
      n_cmp++; if (idx !== 3'd5) begin n_bad++; $display("FAIL shrink_next got %0d want 5", idx); end
   endtask

   task automatic test_disable();
      en = 1'b0;
      step();
      en = 1'b1; mode = 1'b1; sel = 3'd1; div = 16'd0;
      step();
      step();
      step();
      n_cmp++; if (idx !== 3'd3) begin n_bad++; $display("FAIL dis_pre got %0d want 3", idx); end
      en = 1'b0;
      step();
      step();
      n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL dis_out got %h want 00", out); end
      n_cmp++; if (out_l !== 8'hFF) begin n_bad++; $display("FAIL dis_out_l got %h want ff", out_l); end
      n_cmp++; if (idx !== 3'd3) begin n_bad++; $display("FAIL dis_idx got %0d want 3", idx); end
      en = 1'b1; sel = 3'd6;
      step();
      n_cmp++; if (idx !== 3'd6) begin n_bad++; $display("FAIL reen_idx got %0d want 6", idx); end
      n_cmp++; if (out !== 8'h40) begin n_bad++; $display("FAIL reen_out got %h want 40", out); end
      n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reen_wrap got %b want 0", wrap); end
   endtask

   task automatic test_reset_mid();
      step();
      n_cmp++; if (idx !== 3'd7) begin n_bad++; $display("FAIL rmid_pre got %0d want 7", idx); end
      rst_n = 1'b0;
      step();
      n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL rmid_out got %h want 00", out); end
      n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL rmid_idx got %0d want 0", idx); end
      n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL rmid_wrap got %b want 0", wrap); end
      n_cmp++; if (out_l !== 8'hFF) begin n_bad++; $display("FAIL rmid_out_l got %h want ff", out_l); end
      n_cmp++; if (wrap_l !== 1'b0) begin n_bad++; $display("FAIL rmid_wrap_l got %b want 0", wrap_l); end
      rst_n = 1'b1; sel = 3'd2;
      step();
      n_cmp++; if (idx !== 3'd2) begin n_bad++; $display("FAIL rmid_first got %0d want 2", idx); end
      n_cmp++; if (out !== 8'h04) begin n_bad++; $display("FAIL rmid_first_out got %h want 04", out); end
      n_cmp++; if (idx_l !== 3'd2) begin n_bad++; $display("FAIL rmid_first_l got %0d want 2", idx_l); end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 3'd0; div = 16'd0;
      test_reset();
      test_direct();
      test_scan_dwell();
      test_fast_scan();
      test_div_shrink();
      test_disable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
